// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART framing types and constants
//   tx_state_t     : transmit FSM states
//   UART_START_BIT : line level of the start bit
//   UART_STOP_BIT  : line level of the stop bit (and idle)
//   UART_DATA_BITS : data bits per frame
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with latched prescale
//   clk      : clock
//   reset_l  : asynchronous active-low reset
//   clear    : latch max(prescale,1) and restart the count at 0
//   enable   : count while high
//   prescale : clk cycles per bit, sampled only on clear
//   tick     : high on the last cycle of each bit period
module uart_baud_tick #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] period;
  logic [PRESCALE_W-1:0] baudCnt;

  // period is never 0, so period-1 cannot underflow and baudCnt never
  // exceeds period-1, which always fits in PRESCALE_W bits.
  assign tick = enable && (baudCnt == (period - ONE));

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      period  <= ONE;
      baudCnt <= '0;
    end else if (clear) begin
      period  <= (prescale == '0) ? ONE : prescale;
      baudCnt <= '0;
    end else if (enable) begin
      baudCnt <= tick ? '0 : (baudCnt + ONE);
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - serialises words MSB byte first as 8N1 UART frames
//   clk       : clock
//   reset_l   : asynchronous active-low reset
//   s_data    : word to transmit
//   s_valid   : s_data valid
//   s_ready   : block can accept a word (idle and out of reset)
//   prescale  : clk cycles per bit, 0 treated as 1
//   tx        : registered serial line, idle high
//   busy      : a word is in flight
//   word_done : one-cycle pulse in the first idle cycle after a word
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx,
  output logic                  busy,
  output logic                  word_done
);

  localparam int BYTES      = DATA_W / 8;
  localparam int BYTE_IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES - 1);
  localparam logic [2:0]            LAST_BIT  = 3'(UART_DATA_BITS - 1);

  tx_state_t                  state, stateNext;
  logic [DATA_W-1:0]          wordReg, wordNext;
  logic [UART_DATA_BITS-1:0]  shReg, shRegNext;
  logic [2:0]                 bitIdx, bitIdxNext;
  logic [BYTE_IDX_W-1:0]      byteIdx, byteIdxNext;
  logic                       txNext;
  logic                       wordDoneNext;
  logic                       tick;
  logic                       xfer;

  // reset_l gates s_ready so nothing is accepted while reset is held.
  assign s_ready = reset_l && (state == IDLE);
  assign busy    = (state != IDLE);
  assign xfer    = s_valid && s_ready;

  uart_baud_tick #(
    .PRESCALE_W (PRESCALE_W)
  ) u_baud (
    .clk      (clk),
    .reset_l  (reset_l),
    .clear    (xfer),
    .enable   (busy),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= IDLE;
      wordReg   <= '0;
      shReg     <= '0;
      bitIdx    <= '0;
      byteIdx   <= '0;
      tx        <= UART_STOP_BIT;
      word_done <= 1'b0;
    end else begin
      state     <= stateNext;
      wordReg   <= wordNext;
      shReg     <= shRegNext;
      bitIdx    <= bitIdxNext;
      byteIdx   <= byteIdxNext;
      tx        <= txNext;
      word_done <= wordDoneNext;
    end
  end

  // The word register shifts left one byte per frame, so the next byte to
  // send is always in its top 8 bits.
  always_comb begin
    stateNext   = state;
    wordNext    = wordReg;
    shRegNext   = shReg;
    bitIdxNext  = bitIdx;
    byteIdxNext = byteIdx;
    case (state)
      IDLE: begin
        if (xfer) begin
          stateNext   = START;
          wordNext    = s_data;
          shRegNext   = s_data[DATA_W-1 -: UART_DATA_BITS];
          bitIdxNext  = '0;
          byteIdxNext = '0;
        end
      end
      START: begin
        if (tick) begin
          stateNext  = DATA;
          bitIdxNext = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shRegNext = {1'b0, shReg[UART_DATA_BITS-1:1]};
          if (bitIdx == LAST_BIT) begin
            stateNext = STOP;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (byteIdx == LAST_BYTE) begin
            stateNext = IDLE;
          end else begin
            stateNext   = START;
            byteIdxNext = byteIdx + BYTE_IDX_W'(1);
            wordNext    = wordReg << 8;
            shRegNext   = wordNext[DATA_W-1 -: UART_DATA_BITS];
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so tx changes
  // on the same edge as the state it belongs to.
  always_comb begin
    txNext       = UART_STOP_BIT;
    wordDoneNext = 1'b0;
    case (stateNext)
      START:   txNext = UART_START_BIT;
      DATA:    txNext = shRegNext[0];
      default: txNext = UART_STOP_BIT;
    endcase
    if ((state == STOP) && (stateNext == IDLE)) begin
      wordDoneNext = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - directed self-checking bench for uart_word_tx
module tb_uart_word_tx;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] prescale = '0;
  logic        tx;
  logic        busy;
  logic        word_done;

  int checkCount = 0;
  int errorCount = 0;

  uart_word_tx #(
    .DATA_W     (32),
    .PRESCALE_W (16)
  ) dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .prescale  (prescale),
    .tx        (tx),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle transfer; returns just after the accepting edge with s_valid low.
  task automatic sendWord(input logic [31:0] w, input logic [15:0] p, input string tag);
    @(negedge clk);
    s_data   = w;
    prescale = p;
    s_valid  = 1'b1;
    checkVal($sformatf("%s ready", tag), {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    checkVal($sformatf("%s busy", tag), {31'd0, busy}, 32'd1);
  endtask

  // Called just after the transfer edge. Samples every cycle of the 4 frames
  // against the expected line, decodes each byte mid-bit, then checks the
  // word_done cycle that must follow exactly 40*p cycles later.
  task automatic runWord(input logic [31:0] w, input int p, input bit mutate, input string tag);
    int         lineErr;
    logic [7:0] got;
    logic [7:0] expB;
    logic       expBit;
    lineErr = 0;
    for (int b = 0; b < 4; b++) begin
      expB = w[31-8*b -: 8];
      got  = '0;
      for (int k = 0; k < 10; k++) begin
        if (k == 0)      expBit = 1'b0;
        else if (k == 9) expBit = 1'b1;
        else             expBit = expB[k-1];
        for (int c = 0; c < p; c++) begin
          @(negedge clk);
          if (tx !== expBit || word_done !== 1'b0 || busy !== 1'b1) lineErr++;
          if (k >= 1 && k <= 8 && c == p / 2) got[k-1] = tx;
          if (mutate && b == 1 && k == 3 && c == 0) begin
            s_valid  = 1'b1;
            s_data   = 32'hdeadbeef;
            prescale = 16'd9;
          end
          if (mutate && b == 2 && k == 0 && c == 0) s_valid = 1'b0;
        end
      end
      checkVal($sformatf("%s byte%0d", tag, b), {24'd0, got}, {24'd0, expB});
    end
    checkVal($sformatf("%s line", tag), lineErr, 0);
    @(negedge clk);
    checkVal($sformatf("%s word_done", tag), {31'd0, word_done}, 32'd1);
    checkVal($sformatf("%s done ready", tag), {31'd0, s_ready}, 32'd1);
    checkVal($sformatf("%s done tx", tag), {31'd0, tx}, 32'd1);
    checkVal($sformatf("%s done busy", tag), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_l  = 1'b0;
    s_valid  = 1'b1;
    s_data   = 32'h4f727068;
    prescale = 16'd4;
    repeat (3) @(negedge clk);
    checkVal("rst tx", {31'd0, tx}, 32'd1);
    checkVal("rst busy", {31'd0, busy}, 32'd0);
    checkVal("rst ready", {31'd0, s_ready}, 32'd0);
    checkVal("rst word_done", {31'd0, word_done}, 32'd0);

    reset_l = 1'b1;
    #1;
    checkVal("release ready", {31'd0, s_ready}, 32'd1);
    checkVal("release busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    checkVal("release xfer", {31'd0, busy}, 32'd1);
    runWord(32'h4f727068, 4, 1'b0, "orph");
    @(negedge clk);
    checkVal("orph idle", {31'd0, busy}, 32'd0);

    sendWord(32'hA5000001, 16'd0, "p0");
    runWord(32'hA5000001, 1, 1'b0, "p0");

    @(negedge clk);
    s_data   = 32'h11111111;
    prescale = 16'd2;
    s_valid  = 1'b1;
    @(posedge clk);
    #1;
    s_data = 32'h22222222;
    checkVal("b2b1 xfer", {31'd0, busy}, 32'd1);
    runWord(32'h11111111, 2, 1'b0, "b2b1");
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    checkVal("b2b2 xfer", {31'd0, busy}, 32'd1);
    runWord(32'h22222222, 2, 1'b0, "b2b2");
    @(negedge clk);
    checkVal("b2b2 idle", {31'd0, busy}, 32'd0);

    sendWord(32'h4f727068, 16'd4, "mut");
    runWord(32'h4f727068, 4, 1'b1, "mut");
    @(negedge clk);
    checkVal("mut no requeue", {31'd0, busy}, 32'd0);

    sendWord(32'h4f727068, 16'd4, "mrst");
    repeat (86) @(negedge clk);
    checkVal("mrst pre tx", {31'd0, tx}, 32'd0);
    reset_l = 1'b0;
    #1;
    checkVal("mrst tx", {31'd0, tx}, 32'd1);
    checkVal("mrst busy", {31'd0, busy}, 32'd0);
    checkVal("mrst ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    reset_l = 1'b1;
    #1;
    checkVal("mrst release ready", {31'd0, s_ready}, 32'd1);
    sendWord(32'hC3A50F81, 16'd3, "fresh");
    runWord(32'hC3A50F81, 3, 1'b0, "fresh");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Transmit side of the bcrypt host link: takes 32-bit result words (ciphertext) from the bcrypt core over valid/ready and serialises them onto the UART tx line as four 8N1 frames.
- Complements the receive framer that supplies salt/key/cost words to the core.
- Sits between the core's ciphertext output mux and the top-level tx pin.

Parameters:
- DATA_W, 32, word width; must be a multiple of 8.
- BYTES, DATA_W/8, frames per word (derived, not overridden).
- PRESCALE_W, 16, width of the bit-period prescale input.

Ports:
- clk  input  1  clock
- reset_l  input  1  asynchronous, active-low reset
- s_data  input  DATA_W  word to transmit
- s_valid  input  1  s_data valid
- s_ready  output  1  block can accept a word
- prescale  input  PRESCALE_W  clk cycles per UART bit; 0 is treated as 1
- tx  output  1  serial line, idle high
- busy  output  1  a word is in flight
- word_done  output  1  one-cycle pulse after the last stop bit of a word

Behaviour:
- Reset (async, reset_l low): tx=1, s_ready=0 during reset, busy=0, word_done=0, state=IDLE, all counters 0. After release, s_ready=1 in the first cycle.
- Reset mid-word: tx returns high immediately and the word is discarded. There is no partial-frame recovery.
- Handshake:
  - Transfer occurs on a rising clk when s_valid && s_ready.
  - s_ready = (state==IDLE).
  - s_data and max(prescale,1) are latched at the transfer. Later changes to s_data or prescale do not affect the word in flight.
  - s_valid while busy is ignored and not queued.
- Byte order: most-significant byte first (s_data[31:24], then [23:16], [15:8], [7:0]). This makes 0x4f727068 go out as "Orph".
- Bit order within a frame: start bit (0), data bits 0..7 (LSB first), stop bit (1).
- State machine:
  - IDLE: tx=1. On transfer go to START, byte_idx=0, baud_cnt=0.
  - START: tx=0 for P cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shreg[0] for P cycles per bit. At the end of each bit, shift shreg right. After bit 7, go to STOP.
  - STOP: tx=1 for P cycles. At the end, if byte_idx==BYTES-1 go to IDLE and pulse word_done. Otherwise increment byte_idx, load the next byte into shreg and go to START.
- Counters:
  - baud_cnt counts 0..P-1. The bit ends on the cycle where baud_cnt==P-1.
  - bit_idx is 3 bits; byte_idx is 2 bits. Neither wraps within a word.
- Timing:
  - The start bit begins on the cycle after the transfer, so latency is 1 cycle.
  - Word duration: BYTES*10*P cycles. Bytes are contiguous, with no idle between the stop bit and the next start bit.
  - word_done is asserted in the first IDLE cycle, which is also the first cycle s_ready=1 again.
  - Back-to-back words (s_valid held high): the line is idle high for exactly 1 cycle between words.
- busy = (state!=IDLE). tx is driven from a register, so it is glitch-free.
- prescale=0 or 1: P=1, giving 1 cycle per bit and 40 cycles per word.
- prescale max (0xFFFF): baud_cnt must not overflow; it uses PRESCALE_W bits.

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, STOP};
  - constants UART_START_BIT=0, UART_STOP_BIT=1, UART_DATA_BITS=8.
- One sub-module, uart_baud_tick: latched-P counter with a tick output on baud_cnt==P-1, and a clear input asserted at transfer. It is reused by the receive framer.
- The FSM, byte selection and shift register stay in uart_word_tx.

Test Plan:
- Reset check: hold reset_l low with s_valid=1 → tx=1, busy=0, s_ready=0, word_done=0. Release → s_ready=1 next cycle, and no transfer occurs until that cycle.
- s_data=0x4f727068, prescale=4:
  - tx goes low 1 cycle after the transfer;
  - the sampled line decodes to bytes 0x4f,0x72,0x70,0x68;
  - word_done pulses exactly 160 cycles after the start bit begins.
- prescale=0, s_data=0xA5000001 → P=1; line sequence per byte is 0,d0..d7,1; word_done after 40 cycles.
- s_valid held high with words 0x11111111 then 0x22222222, prescale=2 → exactly 1 idle-high cycle between words; the second word transfers on the cycle word_done=1.
- Mid-word, change prescale from 4 to 9 and change s_data → the bit period stays 4 and the transmitted bytes are unchanged; s_valid pulses while busy produce no extra transfer.
- Assert reset_l during DATA of byte 2 → tx=1 immediately. After release, s_ready=1 and a fresh word transmits correctly from byte 0.
